key_event_decoder: RTL and testbench

Classifies debounced key activity into single-click, double-click and long-press events and offers each event to a downstream consumer through a valid/ready handshake. Sits directly downstream of the key debouncer and consumes its one-cycle `key_flag` pulse and `key_state` level. Its output feeds the UART command/parameter logic.

---
 rtl/key_event_decoder.sv | 138 +++++++++++++
 tb/tb_key_event_decoder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// Turns debounced key edges into single, double and long-press events.
// The result sits in a one-entry register that is drained through a valid/ready handshake.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | no gesture in progress
// S_PRESS1    | first press held, timing toward a long press
// S_WAIT2     | short press released, timing the double-click window
// S_PRESS2    | second press held, its release completes a double click
// S_LONG_HOLD | long press already reported, waiting for the release
module key_event_decoder #(
    parameter int LONG_CNT = 50_000_000,
    parameter int DBL_CNT  = 15_000_000,
    parameter int CW       = $clog2((LONG_CNT > DBL_CNT) ? LONG_CNT : DBL_CNT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_flag,
    input  logic       key_state,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       evt_overrun,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_WAIT2,
        S_PRESS2,
        S_LONG_HOLD
    } state_t;

    localparam logic [1:0] EVT_NONE   = 2'b00;
    localparam logic [1:0] EVT_SINGLE = 2'b01;
    localparam logic [1:0] EVT_DOUBLE = 2'b10;
    localparam logic [1:0] EVT_LONG   = 2'b11;

    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CNT - 1);
    localparam logic [CW-1:0] DBL_LAST  = CW'(DBL_CNT - 1);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic            w_press;
    logic            w_release;
    logic            w_emit;
    logic [1:0]      w_emit_code;
    logic            r_valid;
    logic [1:0]      r_code;
    logic            r_overrun;

    assign w_press   = key_flag & ~key_state;
    assign w_release = key_flag &  key_state;

    // Releases take priority over the long timeout, presses over the double-click timeout.
    always_comb begin
        w_next      = r_state;
        w_emit      = 1'b0;
        w_emit_code = EVT_NONE;
        case (r_state)
            S_IDLE: begin
                if (w_press) w_next = S_PRESS1;
            end
            S_PRESS1: begin
                if (w_release) begin
                    w_next = S_WAIT2;
                end else if (r_cnt == LONG_LAST) begin
                    w_next      = S_LONG_HOLD;
                    w_emit      = 1'b1;
                    w_emit_code = EVT_LONG;
                end
            end
            S_WAIT2: begin
                if (w_press) begin
                    w_next = S_PRESS2;
                end else if (r_cnt == DBL_LAST) begin
                    w_next      = S_IDLE;
                    w_emit      = 1'b1;
                    w_emit_code = EVT_SINGLE;
                end
            end
            S_PRESS2: begin
                if (w_release) begin
                    w_next      = S_IDLE;
                    w_emit      = 1'b1;
                    w_emit_code = EVT_DOUBLE;
                end
            end
            S_LONG_HOLD: begin
                if (w_release) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_state == S_PRESS1 || r_state == S_WAIT2)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // An emitted event only fits if the slot is empty or being drained this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_code    <= EVT_NONE;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_emit) begin
                if (!r_valid || evt_ready) begin
                    r_valid <= 1'b1;
                    r_code  <= w_emit_code;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && evt_ready) begin
                r_valid <= 1'b0;
                r_code  <= EVT_NONE;
            end
        end
    end

    assign evt_valid   = r_valid;
    assign evt_code    = r_code;
    assign evt_overrun = r_overrun;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed scenarios for key_event_decoder, checked every cycle against a timestamp-based
// gesture model, plus literal expectations at the cycles called out for each scenario.
module tb_key_event_decoder;

    localparam int LONG_CNT = 20;
    localparam int DBL_CNT  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_flag = 1'b0;
    logic       key_state = 1'b1;
    logic       evt_ready = 1'b1;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_overrun;
    logic       busy;

    key_event_decoder #(.LONG_CNT(LONG_CNT), .DBL_CNT(DBL_CNT)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_flag   (key_flag),
        .key_state  (key_state),
        .evt_valid  (evt_valid),
        .evt_code   (evt_code),
        .evt_ready  (evt_ready),
        .evt_overrun(evt_overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    // Gesture model: phase 0 idle, 1 first press held, 2 gap after short press,
    // 3 second press held, 4 held past the long threshold. t0 stamps the phase start edge.
    int m_phase, m_t0, m_valid, m_code, m_ovr, m_emit, m_ecode;
    bit m_ok = 0;
    bit pr, rl;

    always @(posedge clk) begin
        pr = key_flag && !key_state;
        rl = key_flag && key_state;
        m_emit = 0;
        m_ecode = 0;
        if (rst) begin
            m_phase = 0; m_valid = 0; m_code = 0; m_ovr = 0;
        end else begin
            case (m_phase)
                0: if (pr) begin m_phase = 1; m_t0 = cyc; end
                1: if (rl) begin m_phase = 2; m_t0 = cyc; end
                   else if (cyc - m_t0 == LONG_CNT) begin m_phase = 4; m_emit = 1; m_ecode = 3; end
                2: if (pr) m_phase = 3;
                   else if (cyc - m_t0 == DBL_CNT) begin m_phase = 0; m_emit = 1; m_ecode = 1; end
                3: if (rl) begin m_phase = 0; m_emit = 1; m_ecode = 2; end
                4: if (rl) m_phase = 0;
                default: m_phase = 0;
            endcase
            m_ovr = 0;
            if (m_emit == 1) begin
                if (m_valid == 0 || evt_ready) begin m_valid = 1; m_code = m_ecode; end
                else m_ovr = 1;
            end else if (m_valid == 1 && evt_ready) begin
                m_valid = 0; m_code = 0;
            end
        end
        m_ok = 1;
        cyc++;
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("model_valid",   int'(evt_valid),   m_valid);
            chk("model_code",    int'(evt_code),    m_code);
            chk("model_overrun", int'(evt_overrun), m_ovr);
            chk("model_busy",    int'(busy),        (m_phase != 0) ? 1 : 0);
        end
    end

    // Literal expectations: field 0 valid, 1 code, 2 overrun, 3 busy.
    typedef struct {int rel; int fld; int val;} lit_t;
    lit_t lits[$];

    task automatic add(input int rel, input int fld, input int val);
        lits.push_back('{rel, fld, val});
    endtask

    function automatic int obs(input int f);
        case (f)
            0: return int'(evt_valid);
            1: return int'(evt_code);
            2: return int'(evt_overrun);
            default: return int'(busy);
        endcase
    endfunction

    // Relative cycles 0-1 are reset; key edges at p1/r1/p2/r2 (-1 = none);
    // evt_ready low until rdy_hi (0 = always high); extra 1-cycle reset at rst_at.
    task automatic run_scn(input string nm, input int p1, input int r1, input int p2,
                           input int r2, input int rst_at, input int rdy_hi, input int ncyc);
        for (int n = 0; n < ncyc; n++) begin
            rst       = (n < 2) || (n == rst_at);
            key_flag  = (n == p1) || (n == r1) || (n == p2) || (n == r2);
            key_state = !((n >= p1 && (r1 < 0 || n < r1)) ||
                          (p2 >= 0 && n >= p2 && (r2 < 0 || n < r2)));
            evt_ready = (rdy_hi == 0) || (n >= rdy_hi);
            @(posedge clk);
            @(negedge clk);
            foreach (lits[i])
                if (lits[i].rel == n + 1)
                    chk($sformatf("%s_c%0d_f%0d", nm, n + 1, lits[i].fld), obs(lits[i].fld), lits[i].val);
        end
        lits.delete();
    endtask

    initial begin
        @(negedge clk);

        add(2, 0, 0); add(2, 1, 0); add(2, 2, 0); add(2, 3, 0);
        add(23, 0, 0); add(24, 0, 1); add(24, 1, 1); add(24, 3, 0); add(25, 0, 0);
        run_scn("single", 10, 15, -1, -1, -1, 0, 40);

        add(41, 0, 1); add(41, 1, 2); add(42, 0, 0);
        run_scn("double", 10, 15, 18, 40, -1, 0, 60);

        add(31, 0, 1); add(31, 1, 3); add(32, 0, 0); add(50, 3, 1); add(51, 3, 0); add(52, 0, 0);
        run_scn("long", 10, 50, -1, -1, -1, 0, 70);

        add(31, 0, 0); add(39, 0, 1); add(39, 1, 1);
        run_scn("rel_on_timeout", 10, 30, -1, -1, -1, 0, 60);

        add(31, 0, 1); add(31, 1, 3); add(67, 2, 1); add(67, 1, 3); add(68, 2, 0);
        add(75, 0, 1); add(75, 1, 3); add(76, 0, 0); add(76, 1, 0);
        run_scn("backpressure", 10, 50, 55, 58, -1, 75, 90);

        add(21, 0, 0); add(21, 3, 0); add(31, 0, 0); add(40, 0, 0);
        run_scn("reset_mid", 10, 25, -1, -1, 20, 0, 60);

        add(67, 0, 1); add(67, 1, 1); add(67, 2, 0); add(68, 0, 0);
        run_scn("accept_and_load", 10, 50, 55, 58, -1, 66, 90);

        add(24, 0, 0); add(31, 0, 1); add(31, 1, 2);
        run_scn("press_on_timeout", 10, 15, 23, 30, -1, 0, 50);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
